// File: rtl/md_pkg.sv
// ============================================================================
// md_pkg : op codes, FSM state encoding and constants for muldiv_sched
// Rev 1.0
// ============================================================================
`default_nettype none

package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // LO value written for a divide by zero (HI receives the dividend)
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_sched.sv
// ============================================================================
// muldiv_sched : EX-stage sequencer for mul/div units with HI/LO write-back
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_sched
  import md_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [2:0]          op_code,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  input  logic                annul,
  output logic                mul_signed,
  output logic [DATA_W-1:0]   mul_ina,
  output logic [DATA_W-1:0]   mul_inb,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic                div_start,
  output logic                div_signed,
  output logic [DATA_W-1:0]   div_opdata1,
  output logic [DATA_W-1:0]   div_opdata2,
  output logic                div_annul,
  input  logic [2*DATA_W-1:0] div_result,
  input  logic                div_ready,
  output logic                stallreq_for_ex,
  output logic                hi_we,
  output logic                lo_we,
  output logic [DATA_W-1:0]   hi_wdata,
  output logic [DATA_W-1:0]   lo_wdata
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e           state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_q, b_q, hi_q, lo_q;
  logic                sgn_q;

  logic is_mul, is_div, op_sgn, launch;

  assign is_mul = (op_code == MD_MULT) || (op_code == MD_MULTU);
  assign is_div = (op_code == MD_DIV)  || (op_code == MD_DIVU);
  assign op_sgn = (op_code == MD_MULT) || (op_code == MD_DIV);
  assign launch = (state == ST_IDLE) && op_valid && !annul && (is_mul || is_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nx;
      // Operands are latched at launch so a dropped op_valid cannot disturb the units
      if (launch) begin
        a_q   <= op_a;
        b_q   <= op_b;
        sgn_q <= op_sgn;
        cnt   <= CNT_W'(MUL_LAT - 1);
        if (is_div && (op_b == '0)) begin
          hi_q <= op_a;
          lo_q <= DATA_W'(DIV0_LO);
        end
      end
      if ((state == ST_MUL_WAIT) && !annul) begin
        if (cnt == '0) {hi_q, lo_q} <= mul_result;
        else           cnt <= cnt - 1'b1;
      end
      if ((state == ST_DIV_BUSY) && !annul && div_ready) {hi_q, lo_q} <= div_result;
    end
  end

  always_comb begin
    state_nx        = state;
    stallreq_for_ex = 1'b0;
    mul_signed      = 1'b0;
    mul_ina         = '0;
    mul_inb         = '0;
    div_start       = 1'b0;
    div_signed      = 1'b0;
    div_opdata1     = '0;
    div_opdata2     = '0;
    div_annul       = 1'b0;
    hi_we           = 1'b0;
    lo_we           = 1'b0;
    hi_wdata        = '0;
    lo_wdata        = '0;

    case (state)
      ST_IDLE: begin
        if (op_valid && !annul) begin
          case (op_code)
            MD_MTHI: begin
              hi_we    = 1'b1;
              hi_wdata = op_a;
            end
            MD_MTLO: begin
              lo_we    = 1'b1;
              lo_wdata = op_a;
            end
            MD_MULT, MD_MULTU: begin
              mul_signed      = op_sgn;
              mul_ina         = op_a;
              mul_inb         = op_b;
              stallreq_for_ex = 1'b1;
              state_nx        = ST_MUL_WAIT;
            end
            MD_DIV, MD_DIVU: begin
              stallreq_for_ex = 1'b1;
              if (op_b == '0) begin
                state_nx = ST_DONE;
              end else begin
                div_start   = 1'b1;
                div_signed  = op_sgn;
                div_opdata1 = op_a;
                div_opdata2 = op_b;
                state_nx    = ST_DIV_BUSY;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL_WAIT: begin
        mul_signed = sgn_q;
        mul_ina    = a_q;
        mul_inb    = b_q;
        if (annul) begin
          state_nx = ST_IDLE;
        end else begin
          stallreq_for_ex = 1'b1;
          if (cnt == '0) state_nx = ST_DONE;
        end
      end
      ST_DIV_BUSY: begin
        if (annul) begin
          div_annul = 1'b1;
          state_nx  = ST_IDLE;
        end else begin
          div_start       = 1'b1;
          div_signed      = sgn_q;
          div_opdata1     = a_q;
          div_opdata2     = b_q;
          stallreq_for_ex = 1'b1;
          if (div_ready) state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        if (!annul) begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_wdata = hi_q;
          lo_wdata = lo_q;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Outputs stay quiet for the whole reset cycle, even with an op presented
    if (rst) begin
      state_nx        = ST_IDLE;
      stallreq_for_ex = 1'b0;
      mul_signed      = 1'b0;
      mul_ina         = '0;
      mul_inb         = '0;
      div_start       = 1'b0;
      div_signed      = 1'b0;
      div_opdata1     = '0;
      div_opdata2     = '0;
      div_annul       = 1'b0;
      hi_we           = 1'b0;
      lo_we           = 1'b0;
      hi_wdata        = '0;
      lo_wdata        = '0;
    end
  end

endmodule

`default_nettype wire
